// File: rtl/card_pkg.sv
// Shared card types, rank constants and the baccarat rank-to-value mapping.
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_TEN   = 4'd10;
    localparam card_t CARD_KING  = 4'd13;

    // Face cards, tens, the empty slot and out-of-range injected ranks all count 0.
    function automatic card_t card_value(input card_t rank);
        if (rank >= CARD_ACE && rank < CARD_TEN) begin
            return rank;
        end
        return CARD_EMPTY;
    endfunction

endpackage

// File: rtl/deck_counter.sv
// Free-running card source: cycles 1..MAX_CARD every clock, restarting at DECK_START on reset.
module deck_counter
    import card_pkg::*;
#(
    parameter int unsigned DECK_START = 1,
    parameter int unsigned MAX_CARD   = 13
) (
    input  logic        slow_clock,
    input  logic        reset,
    output logic [3:0]  count
);

    card_t count_d;

    // Wrap on anything at or above MAX_CARD so an illegal value can never persist.
    always_comb begin
        count_d = count + 4'd1;
        if (count >= 4'(MAX_CARD) || count == CARD_EMPTY) begin
            count_d = CARD_ACE;
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            count <= 4'(DECK_START);
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/card_datapath.sv
// Baccarat card datapath: deals cards into six registers on load strobes and reports hand scores.
module card_datapath
    import card_pkg::*;
#(
    parameter int unsigned DECK_START = 1,
    parameter int unsigned MAX_CARD   = 13
) (
    input  logic        slow_clock,
    input  logic        reset,
    input  logic        load_pcard1,
    input  logic        load_pcard2,
    input  logic        load_pcard3,
    input  logic        load_dcard1,
    input  logic        load_dcard2,
    input  logic        load_dcard3,
    input  logic        ext_card_en,
    input  logic [3:0]  ext_card,
    output logic [3:0]  pcard1,
    output logic [3:0]  pcard2,
    output logic [3:0]  pcard3,
    output logic [3:0]  dcard1,
    output logic [3:0]  dcard2,
    output logic [3:0]  dcard3,
    output logic [3:0]  pscore,
    output logic [3:0]  dscore,
    output logic [3:0]  next_card
);

    card_t       dealt;
    logic [4:0]  psum;
    logic [4:0]  dsum;

    deck_counter #(
        .DECK_START (DECK_START),
        .MAX_CARD   (MAX_CARD)
    ) u_deck_counter (
        .slow_clock (slow_clock),
        .reset      (reset),
        .count      (next_card)
    );

    assign dealt = ext_card_en ? ext_card : next_card;

    // Simultaneous strobes are tolerated: every addressed slot takes the same card.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            pcard1 <= CARD_EMPTY;
            pcard2 <= CARD_EMPTY;
            pcard3 <= CARD_EMPTY;
            dcard1 <= CARD_EMPTY;
            dcard2 <= CARD_EMPTY;
            dcard3 <= CARD_EMPTY;
        end else begin
            if (load_pcard1) pcard1 <= dealt;
            if (load_pcard2) pcard2 <= dealt;
            if (load_pcard3) pcard3 <= dealt;
            if (load_dcard1) dcard1 <= dealt;
            if (load_dcard2) dcard2 <= dealt;
            if (load_dcard3) dcard3 <= dealt;
        end
    end

    always_comb begin
        psum   = 5'(card_value(pcard1)) + 5'(card_value(pcard2)) + 5'(card_value(pcard3));
        dsum   = 5'(card_value(dcard1)) + 5'(card_value(dcard2)) + 5'(card_value(dcard3));
        pscore = 4'(psum % 5'd10);
        dscore = 4'(dsum % 5'd10);
    end

endmodule

// File: tb/tb_card_datapath.sv
// Self-checking bench for card_datapath: directed scenarios plus randomized dealing vs. a reference model.
module tb_card_datapath;

    localparam int DeckStart = 1;
    localparam int MaxCard   = 13;

    logic       slow_clock = 1'b0;
    logic       reset;
    logic [5:0] loads;
    logic       ext_card_en;
    logic [3:0] ext_card;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore, next_card;

    int errors = 0;
    int checks = 0;

    // Reference state: slots 0..2 player cards, 3..5 dealer cards.
    int m_card[6];
    int m_next;

    card_datapath #(
        .DECK_START (DeckStart),
        .MAX_CARD   (MaxCard)
    ) dut (
        .slow_clock  (slow_clock),
        .reset       (reset),
        .load_pcard1 (loads[0]),
        .load_pcard2 (loads[1]),
        .load_pcard3 (loads[2]),
        .load_dcard1 (loads[3]),
        .load_dcard2 (loads[4]),
        .load_dcard3 (loads[5]),
        .ext_card_en (ext_card_en),
        .ext_card    (ext_card),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .next_card   (next_card)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int val(input int rank);
        return (rank >= 1 && rank <= 9) ? rank : 0;
    endfunction

    function automatic int score(input int base);
        return (val(m_card[base]) + val(m_card[base+1]) + val(m_card[base+2])) % 10;
    endfunction

    task automatic model_update();
        int dealt;
        if (reset) begin
            foreach (m_card[i]) m_card[i] = 0;
            m_next = DeckStart;
        end else begin
            dealt = ext_card_en ? int'(ext_card) : m_next;
            for (int i = 0; i < 6; i++) if (loads[i]) m_card[i] = dealt;
            m_next = (m_next % MaxCard) + 1;
        end
    endtask

    task automatic check_all();
        check_eq("pcard1", pcard1, m_card[0]);
        check_eq("pcard2", pcard2, m_card[1]);
        check_eq("pcard3", pcard3, m_card[2]);
        check_eq("dcard1", dcard1, m_card[3]);
        check_eq("dcard2", dcard2, m_card[4]);
        check_eq("dcard3", dcard3, m_card[5]);
        check_eq("pscore", pscore, score(0));
        check_eq("dscore", dscore, score(3));
        check_eq("next_card", next_card, m_next);
    endtask

    // One clock: model and DUT both sample the current inputs, then outputs are compared.
    task automatic tick();
        @(posedge slow_clock);
        model_update();
        #1;
        check_all();
    endtask

    task automatic drive(input logic rst, input logic [5:0] ld, input logic en, input int card);
        reset       = rst;
        loads       = ld;
        ext_card_en = en;
        ext_card    = 4'(card);
        tick();
    endtask

    initial begin
        reset = 1'b0; loads = '0; ext_card_en = 1'b0; ext_card = '0;
        foreach (m_card[i]) m_card[i] = 0;
        m_next = DeckStart;
        #2;

        // Reset beats a simultaneous load.
        drive(1'b1, 6'b000001, 1'b1, 5);
        check_eq("rst_pcard1", pcard1, 0);
        check_eq("rst_next", next_card, 1);
        check_eq("rst_pscore", pscore, 0);

        // Idle wrap: 2..13 then back to 1.
        for (int i = 1; i <= 13; i++) begin
            drive(1'b0, 6'b0, 1'b0, 0);
            check_eq("idle_next", next_card, (i % 13) + 1);
        end

        // Injected player cards 5 and 9.
        drive(1'b0, 6'b000001, 1'b1, 5);
        drive(1'b0, 6'b000010, 1'b1, 9);
        check_eq("p_5_9_score", pscore, 4);
        check_eq("p_5_9_pcard3", pcard3, 0);

        // Face cards count zero; out-of-range rank stored raw, counts zero.
        drive(1'b0, 6'b001000, 1'b1, 12);
        drive(1'b0, 6'b010000, 1'b1, 10);
        check_eq("d_face_score", dscore, 0);
        drive(1'b0, 6'b100000, 1'b1, 7);
        check_eq("d_7_score", dscore, 7);
        drive(1'b0, 6'b000100, 1'b1, 15);
        check_eq("p3_raw15", pcard3, 15);
        check_eq("p3_15_score", pscore, 4);

        // Deal from the counter.
        drive(1'b1, 6'b0, 1'b0, 0);
        repeat (3) drive(1'b0, 6'b0, 1'b0, 0);
        check_eq("pre_deal_next", next_card, 4);
        drive(1'b0, 6'b000001, 1'b0, 0);
        check_eq("ctr_pcard1", pcard1, 4);
        check_eq("ctr_pscore", pscore, 4);
        check_eq("ctr_next", next_card, 5);

        // Simultaneous strobes load the same card; reset then clears them.
        drive(1'b0, 6'b100010, 1'b1, 8);
        check_eq("multi_pcard2", pcard2, 8);
        check_eq("multi_dcard3", dcard3, 8);
        check_eq("multi_pscore", pscore, 2);
        check_eq("multi_dscore", dscore, 8);
        drive(1'b1, 6'b0, 1'b0, 0);
        check_eq("clr_pcard2", pcard2, 0);
        check_eq("clr_dcard3", dcard3, 0);

        // Randomized dealing, occasional resets and overlapping strobes.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] ld;
            case ($urandom_range(0, 3))
                0: ld = '0;
                1, 2: ld = 6'(1 << $urandom_range(0, 5));
                default: ld = 6'($urandom);
            endcase
            drive(($urandom_range(0, 39) == 0), ld, 1'($urandom), int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_datapath.md
Name: card_datapath

Overview:
- Responder side of the baccarat hand-control interface. The hand-control FSM issues one-cycle `load_*` strobes; this block answers them.
- On each strobe it deals a card into the addressed card register.
- It returns the current player and dealer scores (`pscore`, `dscore`) and the player's third card (`pcard3`), which the FSM uses for its branching.
- It contains the card source: a free-running deck counter, with an external injection path for deterministic test and bring-up.

Parameters:
- DECK_START, 1: deck counter value after reset (legal range 1..13).
- MAX_CARD, 13: highest card rank; the counter wraps from MAX_CARD to 1.

Ports:
- slow_clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_pcard1  input  1  strobe: deal into player card 1.
- load_pcard2  input  1  strobe: deal into player card 2.
- load_pcard3  input  1  strobe: deal into player card 3.
- load_dcard1  input  1  strobe: deal into dealer card 1.
- load_dcard2  input  1  strobe: deal into dealer card 2.
- load_dcard3  input  1  strobe: deal into dealer card 3.
- ext_card_en  input  1  when 1, dealt value comes from ext_card instead of the deck counter.
- ext_card  input  4  injected card rank.
- pcard1, pcard2, pcard3  output  4 each  player card registers; 0 = no card.
- dcard1, dcard2, dcard3  output  4 each  dealer card registers; 0 = no card.
- pscore  output  4  player hand score, 0..9.
- dscore  output  4  dealer hand score, 0..9.
- next_card  output  4  current deck counter value.

Behaviour:
- Reset (sampled on rising edge, reset=1):
  - all six card registers go to 0;
  - deck counter goes to DECK_START;
  - pscore = dscore = 0.
  - Reset has priority over any load strobe asserted in the same cycle.
- Deck counter:
  - advances every cycle when reset=0, whether or not a load occurs;
  - sequence is 1,2,…,MAX_CARD,1,…;
  - never holds 0 or a value above MAX_CARD.
- Dealt value:
  - dealt = ext_card_en ? ext_card : next_card, sampled in the same cycle as the strobe.
  - The card register holds dealt after that rising edge, i.e. 1-cycle latency.
- Load rules:
  - A register holds its value unless its own strobe is asserted.
  - If several strobes are asserted together (illegal from the FSM), every addressed register loads the same dealt value. No error is flagged.
- Card value:
  - ranks 1..9 → value equals the rank;
  - ranks 0 and 10..15 → value 0. This covers 10/J/Q/K, the empty slot, and out-of-range injected ranks.
  - Out-of-range injected ranks are stored unchanged in the card register.
- Scores:
  - pscore = (val(pcard1)+val(pcard2)+val(pcard3)) mod 10; dscore is the same over the dealer cards.
  - Computed combinationally from the card registers with a 5-bit intermediate sum (max 27).
  - Scores are therefore valid in the same cycle the updated register is visible: 1 cycle after the strobe.
- pcard3 is the raw register, 0 until the third player card is dealt. The FSM reads it directly.
- Reset mid-hand: all cards clear in that cycle; no partial state is retained.

Decomposition:
- Package card_pkg holds:
  - constants CARD_EMPTY=0, CARD_ACE=1, CARD_TEN=10, CARD_KING=13;
  - typedef card_t (logic [3:0]);
  - function card_value(card_t) returning 0..9.
- One sub-module, deck_counter: the wrapping 1..MAX_CARD counter with synchronous reset to DECK_START.
- Card registers and score logic live in card_datapath.

Test Plan:
1. Reset with load_pcard1=1 and ext_card_en=1, ext_card=5 → all cards 0, pscore=dscore=0, next_card=1. The load is ignored.
2. Run 13 idle cycles after reset → next_card steps 2..13, then reads 1 on cycle 13. No card register changes.
3. ext_card_en=1: load_pcard1 with ext_card=5, next cycle load_pcard2 with ext_card=9 → pcard1=5, pcard2=9, pscore=4, pcard3=0.
4. ext_card_en=1: dcard1=12, dcard2=10 → dscore=0. Then dcard3=7 → dscore=7. Then inject ext_card=15 into pcard3 → pcard3 reads 15 and contributes 0 to pscore.
5. Counter deal: reset, 3 idle cycles (next_card=4), pulse load_pcard1 with ext_card_en=0 → pcard1=4, pscore=4, next_card=5.
6. Simultaneous strobes load_pcard2 and load_dcard3 with ext_card=8 → both registers read 8, pscore and dscore each include 8. A following reset clears both.
